// File: rtl/axi_mem_arbiter.sv
// AXI master-port arbiter: icache/dcache refill reads share AR/R (one burst in flight),
// the write buffer drives AW/W/B serially. Optional macro ARB_RR_EN enables round-robin read grants.
module axi_mem_arbiter #(
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    // icache refill
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_rvalid,
    // dcache refill
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_ack,
    output logic        d_rvalid,
    // AXI read address / data control
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic        arvalid,
    input  logic        arready,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,
    // write buffer
    input  logic [31:0] wb_addr,
    input  logic        wb_valid,
    input  logic        wb_last,
    output logic        wb_awready,
    output logic        wb_wready,
    output logic        wb_bvalid,
    input  logic        wb_bready,
    // AXI write control
    output logic        awvalid,
    input  logic        awready,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    // state visibility
    output logic [1:0]  dbg_rd_state,
    output logic [1:0]  dbg_wr_state
);

    localparam int LINE_LSB = OFFSET_WIDTH + 2;
    localparam logic [7:0] ARLEN = 8'((1 << OFFSET_WIDTH) - 1);

    // Handshake rule on every channel: a transfer happens in a cycle where valid and
    // ready are both high; a raised arvalid is held until arready.
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_e;
    typedef enum logic [1:0] {W_ADDR = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;

    rd_state_e            rd_state_q, rd_state_d;
    wr_state_e            wr_state_q, wr_state_d;
    logic                 own_i_q, own_i_d;
    logic [31:0]          ara_q, ara_d;
    logic                 wr_busy_q, wr_busy_d;
    logic [31:LINE_LSB]   wr_line_q, wr_line_d;
    logic                 en_q;
    logic                 hazard;
    logic                 d_elig;
    logic                 pick_i;
    logic                 unused_wb_low;

    assign unused_wb_low = ^wb_addr[LINE_LSB-1:0];

    // en_q holds every handshake output low until the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q       <= 1'b0;
            rd_state_q <= R_IDLE;
            wr_state_q <= W_ADDR;
            own_i_q    <= 1'b0;
            ara_q      <= '0;
            wr_busy_q  <= 1'b0;
            wr_line_q  <= '0;
        end else begin
            en_q       <= 1'b1;
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            own_i_q    <= own_i_d;
            ara_q      <= ara_d;
            wr_busy_q  <= wr_busy_d;
            wr_line_q  <= wr_line_d;
        end
    end

    // Dcache refill must not overtake a write-back of the same line.
    always_comb begin
        hazard = (wr_busy_q && (d_addr[31:LINE_LSB] == wr_line_q)) ||
                 ((wr_state_q == W_ADDR) && wb_valid &&
                  (d_addr[31:LINE_LSB] == wb_addr[31:LINE_LSB]));
        d_elig = d_req && !hazard;
    end

`ifdef ARB_RR_EN
    logic last_i_q, last_i_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_i_q <= 1'b1;
        end else begin
            last_i_q <= last_i_d;
        end
    end

    always_comb begin
        last_i_d = last_i_q;
        if (rd_state_q == R_AR && arready) begin
            last_i_d = own_i_q;
        end
        pick_i = 1'b0;
        if (d_elig && i_req) begin
            pick_i = !last_i_q;
        end else if (!d_elig && i_req) begin
            pick_i = 1'b1;
        end
    end
`else
    always_comb begin
        pick_i = !d_elig && i_req;
    end
`endif

    // Read FSM: next state and outputs.
    always_comb begin
        rd_state_d = rd_state_q;
        own_i_d    = own_i_q;
        ara_d      = ara_q;
        arvalid    = 1'b0;
        rready     = 1'b0;
        i_ack      = 1'b0;
        d_ack      = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (en_q && (d_elig || i_req)) begin
                    rd_state_d = R_AR;
                    own_i_d    = pick_i;
                    ara_d      = pick_i ? i_addr : d_addr;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    i_ack      = own_i_q;
                    d_ack      = !own_i_q;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rready   = 1'b1;
                i_rvalid = own_i_q && rvalid;
                d_rvalid = !own_i_q && rvalid;
                if (rvalid && rlast) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write FSM: next state and outputs.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_busy_d  = wr_busy_q;
        wr_line_d  = wr_line_q;
        awvalid    = 1'b0;
        wb_awready = 1'b0;
        wvalid     = 1'b0;
        wb_wready  = 1'b0;
        bready     = 1'b0;
        wb_bvalid  = 1'b0;
        unique case (wr_state_q)
            W_ADDR: begin
                awvalid    = en_q && wb_valid;
                wb_awready = en_q && awready;
                if (en_q && wb_valid && awready) begin
                    wr_line_d  = wb_addr[31:LINE_LSB];
                    wr_busy_d  = 1'b1;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wvalid    = wb_valid;
                wb_wready = wready;
                if (wb_valid && wready && wb_last) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bready    = wb_bready;
                wb_bvalid = bvalid;
                if (bvalid && wb_bready) begin
                    wr_busy_d  = 1'b0;
                    wr_state_d = W_ADDR;
                end
            end
            default: wr_state_d = W_ADDR;
        endcase
    end

    assign araddr       = ara_q;
    assign arlen        = ARLEN;
    assign dbg_rd_state = rd_state_q;
    assign dbg_wr_state = wr_state_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: arbitration order, AR stall, RAW hazard,
// read/write overlap and mid-burst reset, with hand-computed expectations.
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_ack, i_rvalid, d_ack, d_rvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [31:0] wb_addr;
  logic        wb_valid, wb_last, wb_awready, wb_wready, wb_bvalid, wb_bready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  dbg_rd_state, dbg_wr_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_mem_arbiter #(.OFFSET_WIDTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rvalid(d_rvalid),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .wb_addr(wb_addr), .wb_valid(wb_valid), .wb_last(wb_last),
    .wb_awready(wb_awready), .wb_wready(wb_wready), .wb_bvalid(wb_bvalid),
    .wb_bready(wb_bready),
    .awvalid(awvalid), .awready(awready), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Four beats with one rvalid gap; ends in the cycle after rlast.
  task automatic run_burst(input string tag, input logic exp_i);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        rvalid = 1'b0;
        #1;
        chk({tag, "_gap_i"}, {31'd0, i_rvalid}, 32'd0);
        chk({tag, "_gap_d"}, {31'd0, d_rvalid}, 32'd0);
        step();
      end
      rvalid = 1'b1;
      rlast  = (k == 3);
      #1;
      chk({tag, "_i_rvalid"}, {31'd0, i_rvalid}, {31'd0, exp_i});
      chk({tag, "_d_rvalid"}, {31'd0, d_rvalid}, {31'd0, !exp_i});
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    #1;
    chk({tag, "_rready_end"}, {31'd0, rready}, 32'd0);
  endtask

  // Starts in an R_IDLE cycle with the request already driven (arready assumed 1).
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic exp_i);
    #1;
    chk({tag, "_sel_arvalid"}, {31'd0, arvalid}, 32'd0);
    step();
    #1;
    chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd1);
    chk({tag, "_araddr"}, araddr, exp_addr);
    chk({tag, "_i_ack"}, {31'd0, i_ack}, {31'd0, exp_i});
    chk({tag, "_d_ack"}, {31'd0, d_ack}, {31'd0, !exp_i});
    step();
    if (exp_i) i_req = 1'b0;
    else d_req = 1'b0;
    #1;
    chk({tag, "_ack_off"}, {30'd0, i_ack, d_ack}, 32'd0);
    chk({tag, "_rready"}, {31'd0, rready}, 32'd1);
    run_burst(tag, exp_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with busy-looking inputs: every output must stay low
    rstn = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0; d_addr = 32'h0;
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b0;
    wb_addr = 32'h9000; wb_valid = 1'b1; wb_last = 1'b0; wb_bready = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {arvalid, rready, i_ack, d_ack, i_rvalid, d_rvalid, awvalid, wb_awready,
                     wvalid, wb_wready, bready, wb_bvalid}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_states", {28'd0, dbg_rd_state, dbg_wr_state}, 32'd0);
    i_req = 1'b0; d_req = 1'b0; rvalid = 1'b0; bvalid = 1'b0; wb_bready = 1'b0; wready = 1'b0;
    rstn = 1'b1;
    #1;
    chk("rel_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rel_wb_awready", {31'd0, wb_awready}, 32'd0);
    wb_valid = 1'b0; awready = 1'b0;
    step();
    chk("arlen", {24'd0, arlen}, 32'd3);

    // both requesters at once: dcache first, then icache
    arready = 1'b1;
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_addr = 32'h2000;
    serve("t1d", 32'h2000, 1'b0);
    serve("t1i", 32'h1000, 1'b1);

    // AR stalled five cycles
    step();
    arready = 1'b0;
    d_req = 1'b1; d_addr = 32'h2040;
    #1;
    chk("t2_sel", {31'd0, arvalid}, 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_hold_arvalid", {31'd0, arvalid}, 32'd1);
      chk("t2_hold_araddr", araddr, 32'h2040);
      chk("t2_hold_ack", {30'd0, i_ack, d_ack}, 32'd0);
      step();
    end
    arready = 1'b1;
    #1;
    chk("t2_d_ack", {30'd0, i_ack, d_ack}, 32'd1);
    step();
    d_req = 1'b0;
    #1;
    chk("t2_ack_off", {30'd0, i_ack, d_ack}, 32'd0);
    run_burst("t2", 1'b0);

    // both again after a dcache grant
    i_req = 1'b1; i_addr = 32'h1100;
    d_req = 1'b1; d_addr = 32'h2100;
`ifdef ARB_RR_EN
    serve("rr_i", 32'h1100, 1'b1);
    serve("rr_d", 32'h2100, 1'b0);
`else
    serve("fx_d", 32'h2100, 1'b0);
    serve("fx_i", 32'h1100, 1'b1);
`endif

    // write-back to 0x3000 blocks dcache refill of the same line
    step();
    wb_addr = 32'h3000; wb_valid = 1'b1; awready = 1'b1;
    d_req = 1'b1; d_addr = 32'h3008;
    #1;
    chk("t3_awvalid", {31'd0, awvalid}, 32'd1);
    chk("t3_wb_awready", {31'd0, wb_awready}, 32'd1);
    step();
    awready = 1'b0; wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wb_last = (k == 3);
      #1;
      chk("t3_wvalid", {31'd0, wvalid}, 32'd1);
      chk("t3_wb_wready", {31'd0, wb_wready}, 32'd1);
      chk("t3_blocked", {31'd0, arvalid}, 32'd0);
      step();
    end
    wb_valid = 1'b0; wb_last = 1'b0; wready = 1'b0; wb_bready = 1'b1;
    i_req = 1'b1; i_addr = 32'h4000;
    serve("t3i", 32'h4000, 1'b1);
    bvalid = 1'b1;
    #1;
    chk("t3_wb_bvalid", {31'd0, wb_bvalid}, 32'd1);
    chk("t3_bready", {31'd0, bready}, 32'd1);
    chk("t3_still_blocked", {31'd0, arvalid}, 32'd0);
    step();
    bvalid = 1'b0; wb_bready = 1'b0;
    serve("t3d", 32'h3008, 1'b0);

    // read to 0x5000 overlapping write to 0x6000
    step();
    d_req = 1'b1; d_addr = 32'h5000;
    wb_valid = 1'b1; wb_addr = 32'h6000; awready = 1'b1;
    #1;
    chk("t4_awvalid", {31'd0, awvalid}, 32'd1);
    chk("t4_sel", {31'd0, arvalid}, 32'd0);
    step();
    awready = 1'b0; wready = 1'b1;
    #1;
    chk("t4_arvalid", {31'd0, arvalid}, 32'd1);
    chk("t4_araddr", araddr, 32'h5000);
    chk("t4_d_ack", {30'd0, i_ack, d_ack}, 32'd1);
    chk("t4_wvalid0", {31'd0, wvalid}, 32'd1);
    step();
    d_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rlast = (k == 3);
      wb_valid = (k < 3); wb_last = (k == 2);
      #1;
      chk("t4_d_rvalid", {31'd0, d_rvalid}, 32'd1);
      chk("t4_i_rvalid", {31'd0, i_rvalid}, 32'd0);
      chk("t4_wvalid", {31'd0, wvalid}, {31'd0, (k < 3)});
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; wb_valid = 1'b0; wb_last = 1'b0; wready = 1'b0;
    bvalid = 1'b1; wb_bready = 1'b1;
    #1;
    chk("t4_wb_bvalid", {31'd0, wb_bvalid}, 32'd1);
    chk("t4_bready", {31'd0, bready}, 32'd1);
    chk("t4_rready_idle", {31'd0, rready}, 32'd0);
    step();
    bvalid = 1'b0; wb_bready = 1'b0;
    #1;
    chk("t4_states", {28'd0, dbg_rd_state, dbg_wr_state}, 32'd0);

    // reset asserted during beat 2 of a dcache burst
    d_req = 1'b1; d_addr = 32'h7000;
    step();
    step();
    step();
    d_req = 1'b0;
    rvalid = 1'b1;
    #1;
    chk("t5_beat1", {31'd0, d_rvalid}, 32'd1);
    step();
    #1;
    rstn = 1'b0;
    #1;
    chk("t5_rst_outs", {arvalid, rready, i_ack, d_ack, i_rvalid, d_rvalid}, 32'd0);
    chk("t5_rst_state", {30'd0, dbg_rd_state}, 32'd0);
    rvalid = 1'b0;
    step();
    rstn = 1'b1;
    #1;
    chk("t5_rel_arvalid", {31'd0, arvalid}, 32'd0);
    step();
    i_req = 1'b1; i_addr = 32'h8000;
    serve("t5i", 32'h8000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
